// File: rtl/divs_restoring_seq_if.sv
// Operand/result handshake bundle for the sequential signed divider.
// master drives operands and consumes results; slave is the divider.
interface divs_restoring_seq_if #(
  parameter int WIDTH = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2*WIDTH-1:0]     dividend;
  logic [WIDTH-1:0]       divisor;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]       remainder;
  logic                   div_by_zero;
  logic                   overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/divs_restoring_seq.sv
// Sequential signed divider: radix-2 restoring iteration on magnitudes, 2W-bit
// dividend / W-bit divisor. Define DIVS_BACK_TO_BACK_EN to accept in DONE.
module divs_restoring_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  divs_restoring_seq_if.slave  bus
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  typedef struct packed {
    logic [DW-1:0]    quot;
    logic [WIDTH-1:0] rem;
    logic             dbz;
    logic             ovf;
  } result_t;

  state_t state, state_nxt;
  logic   ready;
  logic   accept;
  logic   dvs_zero;

  logic [DW-1:0]    shf_q;      // dividend magnitude, becomes quotient magnitude
  logic [WIDTH-1:0] prem_q;
  logic [WIDTH-1:0] dvs_abs_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_q_q;
  logic             sign_r_q;
  result_t          res_q;

  // Magnitudes taken one bit wider so the most-negative values negate exactly.
  logic [DW:0]      dvd_ext;
  logic [WIDTH:0]   dvs_ext;
  logic [DW-1:0]    dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  assign dvd_ext  = {bus.dividend[DW-1], bus.dividend};
  assign dvs_ext  = {bus.divisor[WIDTH-1], bus.divisor};
  assign dvd_mag  = dvd_ext[DW]    ? DW'(-dvd_ext)    : bus.dividend;
  assign dvs_mag  = dvs_ext[WIDTH] ? WIDTH'(-dvs_ext) : bus.divisor;
  assign dvs_zero = (bus.divisor == '0);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           qbit;

  assign shifted = {prem_q, shf_q[DW-1]};
  assign trial   = shifted - {1'b0, dvs_abs_q};
  assign qbit    = ~trial[WIDTH];

  logic [DW-1:0] quot_fix;
  logic          ovf_fix;

  assign quot_fix = sign_q_q ? -shf_q : shf_q;
  assign ovf_fix  = (shf_q == {1'b1, {(DW-1){1'b0}}}) && !sign_q_q;

  assign accept = bus.in_valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
`ifdef DIVS_BACK_TO_BACK_EN
    ready     = (state == IDLE) || ((state == DONE) && bus.out_ready);
`else
    ready     = (state == IDLE);
`endif
    case (state)
      IDLE: if (accept) state_nxt = dvs_zero ? DONE : CALC;
      CALC: if (cnt_q == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = accept ? (dvs_zero ? DONE : CALC) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shf_q     <= '0;
      prem_q    <= '0;
      dvs_abs_q <= '0;
      cnt_q     <= '0;
      sign_q_q  <= 1'b0;
      sign_r_q  <= 1'b0;
      res_q     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            sign_q_q  <= bus.dividend[DW-1] ^ bus.divisor[WIDTH-1];
            sign_r_q  <= bus.dividend[DW-1];
            shf_q     <= dvd_mag;
            dvs_abs_q <= dvs_mag;
            prem_q    <= '0;
            cnt_q     <= CW'(DW - 1);
            if (dvs_zero) begin
              res_q.quot <= '1;
              res_q.rem  <= '0;
              res_q.dbz  <= 1'b1;
              res_q.ovf  <= 1'b0;
            end
          end
        end
        CALC: begin
          shf_q  <= {shf_q[DW-2:0], qbit};
          prem_q <= qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          cnt_q  <= cnt_q - 1'b1;
        end
        FIX: begin
          // A positive 2^(2W-1) magnitude wraps to the most-negative code.
          res_q.quot <= quot_fix;
          res_q.rem  <= sign_r_q ? -prem_q : prem_q;
          res_q.dbz  <= 1'b0;
          res_q.ovf  <= ovf_fix;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = res_q.quot;
  assign bus.remainder   = res_q.rem;
  assign bus.div_by_zero = res_q.dbz;
  assign bus.overflow    = res_q.ovf;
endmodule

// File: tb/tb_divs_restoring_seq.sv
// Self-checking bench for divs_restoring_seq: directed cases, stall, reset abort,
// back-to-back (when DIVS_BACK_TO_BACK_EN is defined) and random ops vs integer model.
module tb_divs_restoring_seq;
  localparam int W  = 4;
  localparam int DW = 2 * W;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  divs_restoring_seq_if #(.WIDTH(W)) bus ();
  divs_restoring_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed integer division, truncating toward zero.
  task automatic model(input logic [DW-1:0] a, input logic [W-1:0] b,
                       output logic [DW-1:0] q, output logic [W-1:0] r,
                       output logic dz, output logic ov);
    int sa, sb, qi, ri;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      q = '1; r = '0; dz = 1'b1; ov = 1'b0;
    end else begin
      qi = sa / sb;
      ri = sa % sb;
      q  = qi[DW-1:0];
      r  = ri[W-1:0];
      dz = 1'b0;
      ov = (qi > (2 ** (DW - 1)) - 1);
    end
  endtask

  task automatic accept_op(input logic [DW-1:0] a, input logic [W-1:0] b, input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.dividend = DW'($urandom);
    bus.divisor  = W'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input logic [DW-1:0] a, input logic [W-1:0] b,
                              input int lat, input string tag);
    logic [DW-1:0] q;
    logic [W-1:0]  r;
    logic          dz, ov;
    model(a, b, q, r, dz, ov);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_quotient"},  64'(bus.quotient), 64'(q));
    chk({tag, "_remainder"}, 64'(bus.remainder), 64'(r));
    chk({tag, "_dbz"},       64'(bus.div_by_zero), 64'(dz));
    chk({tag, "_ovf"},       64'(bus.overflow), 64'(ov));
    chk({tag, "_latency"},   64'(lat), dz ? 64'd1 : 64'(DW + 2));
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_post_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_post_in_ready"},  64'(bus.in_ready), 64'd1);
  endtask

  task automatic run_op(input logic [DW-1:0] a, input logic [W-1:0] b, input string tag);
    int lat;
    accept_op(a, b, tag);
    wait_result(lat);
    check_result(a, b, lat, tag);
    consume(tag);
  endtask

  initial begin
    int lat;
    logic [DW-1:0] ra;
    logic [W-1:0]  rb;

    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
    chk("rst_quotient",  64'(bus.quotient), 64'd0);
    chk("rst_remainder", 64'(bus.remainder), 64'd0);
    chk("rst_flags",     64'({bus.div_by_zero, bus.overflow}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h64, 4'h7, "d100_7");
    chk("d100_7_q_const", 64'(bus.quotient), 64'h0E);
    chk("d100_7_r_const", 64'(bus.remainder), 64'h2);
    run_op(8'hF9, 4'h2, "dm7_2");
    chk("dm7_2_q_const", 64'(bus.quotient), 64'hFD);
    chk("dm7_2_r_const", 64'(bus.remainder), 64'hF);
    run_op(8'h07, 4'hE, "d7_m2");
    chk("d7_m2_q_const", 64'(bus.quotient), 64'hFD);
    chk("d7_m2_r_const", 64'(bus.remainder), 64'h1);
    run_op(8'h80, 4'hF, "dmin_m1");
    chk("dmin_m1_ovf_const", 64'(bus.overflow), 64'd1);
    chk("dmin_m1_q_const",   64'(bus.quotient), 64'h80);
    run_op(8'h80, 4'h8, "dmin_m8");
    chk("dmin_m8_q_const", 64'(bus.quotient), 64'h10);
    run_op(8'h80, 4'h1, "dmin_1");
    run_op(8'h32, 4'h0, "d50_0");
    chk("d50_0_q_const", 64'(bus.quotient), 64'hFF);
    run_op(8'h7F, 4'h8, "dmax_m8");

    // Stall in DONE: results stay put, no new operand accepted.
    accept_op(8'h64, 4'h7, "stall");
    wait_result(lat);
    check_result(8'h64, 4'h7, lat, "stall");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("stall%0d_quotient", i),  64'(bus.quotient), 64'h0E);
      chk($sformatf("stall%0d_remainder", i), 64'(bus.remainder), 64'h2);
      chk($sformatf("stall%0d_in_ready", i),  64'(bus.in_ready), 64'd0);
    end

    // Consume with a new operand offered in the same cycle.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.dividend  = 8'hF9;
    bus.divisor   = 4'h2;
    #1;
`ifdef DIVS_BACK_TO_BACK_EN
    chk("b2b_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    wait_result(lat);
    check_result(8'hF9, 4'h2, lat, "b2b");
    consume("b2b");
`else
    chk("nob2b_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("nob2b_out_valid", 64'(bus.out_valid), 64'd0);
    chk("nob2b_idle",      64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("nob2b_no_accept", 64'(bus.in_ready), 64'd1);
`endif

    // Reset in the middle of CALC aborts the operation.
    accept_op(8'h64, 4'h7, "abort");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_in_ready",  64'(bus.in_ready), 64'd1);
    chk("abort_quotient",  64'(bus.quotient), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_result", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h64, 4'h7, "after_abort");
    chk("after_abort_q_const", 64'(bus.quotient), 64'h0E);

    for (int i = 0; i < 40; i++) begin
      ra = DW'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 4'h0 : W'($urandom);
      if (i == 0) ra = 8'h80;
      run_op(ra, rb, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
